// File: rtl/popcnt_pkg.sv
// Shared types and constants for the popcount accumulator.
// Holds the counter result type, FSM encoding and stage-1 latency.
package popcnt_pkg;

    typedef logic [2:0] cnt6_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int C63_LAT = 1;

    function automatic cnt6_t pop6(input logic [5:0] v);
        cnt6_t c;
        c = '0;
        for (int i = 0; i < 6; i++) begin
            c = c + cnt6_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/c6_3.sv
// 6:3 counter: compresses six input bits into a 3-bit ones count.
// LEAVEC="TRUE" leaves C0[5] out of the count for carry chaining.
module c6_3
    import popcnt_pkg::*;
#(
    parameter string OUTREG = "TRUE",
    parameter string LEAVEC = "FALSE"
) (
    input  logic       clk,
    input  logic [5:0] C0,
    output cnt6_t      S
);

    cnt6_t cnt_d;

    generate
        if (LEAVEC == "TRUE") begin : g_leave
            assign cnt_d = pop6({1'b0, C0[4:0]});
        end else begin : g_full
            assign cnt_d = pop6(C0);
        end
    endgenerate

    generate
        if (OUTREG == "TRUE") begin : g_reg
            cnt6_t s_q;
            // Datapath register: loads every cycle, intentionally not reset
            always_ff @(posedge clk) begin
                s_q <= cnt_d;
            end
            assign S = s_q;
        end else begin : g_comb
            assign S = cnt_d;
        end
    endgenerate

endmodule

// File: rtl/popcnt_accum.sv
// Streaming popcount accumulator: c6_3 stage feeding a saturating
// per-frame sum, with the frame total presented on valid/ready.
module popcnt_accum
    import popcnt_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [5:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    logic             accept;
    cnt6_t            cnt;
    logic [C63_LAT-1:0] s1_valid_q;
    logic [C63_LAT-1:0] s1_last_q;
    logic             s1_valid;
    logic             s1_last;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] base_acc;
    logic             base_ovf;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat_acc;
    logic             sat_ovf;
    logic             load;

    assign accept = in_valid && in_ready;

    c6_3 #(
        .OUTREG("TRUE"),
        .LEAVEC("FALSE")
    ) u_c63 (
        .clk(clk),
        .C0 (in_data),
        .S  (cnt)
    );

    // Control tags track the counter latency alongside the data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= '0;
            s1_last_q  <= '0;
        end else begin
            s1_valid_q[0] <= accept;
            s1_last_q[0]  <= in_last;
            for (int i = 1; i < C63_LAT; i++) begin
                s1_valid_q[i] <= s1_valid_q[i-1];
                s1_last_q[i]  <= s1_last_q[i-1];
            end
        end
    end

    assign s1_valid = s1_valid_q[C63_LAT-1];
    assign s1_last  = s1_last_q[C63_LAT-1];

    assign in_ready = !(out_valid_q && !out_ready) && !(s1_valid && s1_last);

    // Only RUN carries a partial sum; IDLE and DONE start a fresh frame
    always_comb begin
        base_acc = (state_q == RUN) ? acc_q : '0;
        base_ovf = (state_q == RUN) ? ovf_q : 1'b0;
        sum      = {1'b0, base_acc} + {{(ACC_W-2){1'b0}}, cnt};
        sat_acc  = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        sat_ovf  = base_ovf | sum[ACC_W];
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
            RUN: ;
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
        if (s1_valid) begin
            if (s1_last) begin
                load    = 1'b1;
                state_d = DONE;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                state_d = RUN;
                acc_d   = sat_acc;
                ovf_d   = sat_ovf;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_sum_d   = sat_acc;
            out_ovf_d   = sat_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_popcnt_accum.sv
// Directed and random frames against a queue-based popcount model,
// run on a 16-bit and a 4-bit accumulator instance in parallel.
module tb_popcnt_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, in_ready4;
    logic        out_valid, out_valid4;
    logic [15:0] out_sum;
    logic [3:0]  out_sum4;
    logic        out_ovf, out_ovf4;

    int nchk = 0;
    int nerr = 0;

    int          frame_tot;
    int          exp_q[$];
    logic [15:0] gs_q[$];
    logic        go_q[$];
    logic [3:0]  gs4_q[$];
    logic        go4_q[$];

    always #5 clk = ~clk;

    popcnt_accum #(.ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    popcnt_accum #(.ACC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_sum(out_sum4), .out_ovf(out_ovf4)
    );

    // Capture every consumed result
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            gs_q.push_back(out_sum);
            go_q.push_back(out_ovf);
        end
        if (rst_n && out_valid4 && out_ready) begin
            gs4_q.push_back(out_sum4);
            go4_q.push_back(out_ovf4);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] d, input logic l, output int waits);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!in_ready && n < 200) begin
            cyc();
            n++;
        end
        check("send_in_ready", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        waits = n;
        frame_tot += $countones(d);
        if (l) begin
            exp_q.push_back(frame_tot);
            frame_tot = 0;
        end
    endtask

    task automatic get_result(input string tag);
        int n;
        int tot;
        n = 0;
        while ((gs_q.size() == 0 || gs4_q.size() == 0) && n < 100) begin
            cyc();
            n++;
        end
        check({tag, "_present"}, 32'(gs_q.size() != 0 && gs4_q.size() != 0), 1);
        if (gs_q.size() != 0 && gs4_q.size() != 0 && exp_q.size() != 0) begin
            tot = exp_q.pop_front();
            check({tag, "_sum16"}, 32'(gs_q.pop_front()), (tot > 65535) ? 65535 : tot);
            check({tag, "_ovf16"}, 32'(go_q.pop_front()), 32'(tot > 65535));
            check({tag, "_sum4"}, 32'(gs4_q.pop_front()), (tot > 15) ? 15 : tot);
            check({tag, "_ovf4"}, 32'(go4_q.pop_front()), 32'(tot > 15));
        end
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        frame_tot = 0;
        cyc();
        cyc();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_ovf", 32'(out_ovf), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        cyc();

        // Three-beat frame, total 10, latency check
        send(6'b111111, 1'b0, w);
        send(6'b000001, 1'b0, w);
        send(6'b101010, 1'b1, w);
        check("f1_valid_t1", 32'(out_valid), 0);
        check("f1_bubble", 32'(in_ready), 0);
        check("f1_bubble4", 32'(in_ready4), 0);
        cyc();
        check("f1_valid_t2", 32'(out_valid), 1);
        check("f1_sum", 32'(out_sum), 10);
        check("f1_ovf", 32'(out_ovf), 0);
        get_result("f1");

        // Saturation on the 4-bit instance, then a clean frame
        send(6'b111111, 1'b0, w);
        send(6'b111111, 1'b0, w);
        send(6'b111111, 1'b1, w);
        get_result("sat");
        send(6'b000011, 1'b1, w);
        get_result("after_sat");

        // Back-to-back single-beat frames with one bubble
        send(6'b000111, 1'b1, w);
        send(6'b011111, 1'b1, w);
        check("b2b_bubble", w, 1);
        get_result("b2b_a");
        get_result("b2b_b");

        // Backpressure holds the result and stalls input
        out_ready = 1'b0;
        send(6'b001111, 1'b1, w);
        cyc();
        in_valid = 1'b1;
        in_data  = 6'b000001;
        in_last  = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_sum", 32'(out_sum), 4);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        send(6'b000001, 1'b0, w);
        send(6'b000011, 1'b1, w);
        get_result("bp_held");
        get_result("bp_next");

        // Reset mid-frame discards the partial sum
        send(6'b111111, 1'b0, w);
        send(6'b111111, 1'b0, w);
        rst_n = 1'b0;
        cyc();
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_sum", 32'(out_sum), 0);
        check("mid_rst_ovf", 32'(out_ovf), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        frame_tot = 0;
        send(6'b000001, 1'b1, w);
        get_result("post_rst");

        // 100-beat random frame with random gaps in in_valid
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 6'($urandom);
                cyc();
            end
            send(6'($urandom), (i == 99), w);
        end
        get_result("rand");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
